// File: rtl/sme_pkg.sv
// Shared definitions for the wildcard string-match engine.
//   - character constants for the pattern meta characters
//   - search state encoding
//   - idx_w(): index width needed to address a given string depth
package sme_pkg;

    localparam logic [7:0] CH_CARET  = 8'h5E;  // '^' start anchor
    localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$' end anchor
    localparam logic [7:0] CH_DOT    = 8'h2E;  // '.' any single character
    localparam logic [7:0] CH_STAR   = 8'h2A;  // '*' gap of zero or more characters
    localparam logic [7:0] CH_SPACE  = 8'h20;  // word separator

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_PRE  = 2'd1,
        S_SUF  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sme_wild_matcher_if.sv
// Character-stream / result interface of the match engine.
//   chardata, isstring, ispattern : front end -> engine
//   busy, valid, match, match_index : engine -> result collector
// master = front end / collector side, slave = engine side.
interface sme_wild_matcher_if #(
    parameter int IDXW = 5
);
    logic [7:0]      chardata;
    logic            isstring;
    logic            ispattern;
    logic            busy;
    logic            valid;
    logic            match;
    logic [IDXW-1:0] match_index;

    modport master (
        output chardata, isstring, ispattern,
        input  busy, valid, match, match_index
    );

    modport slave (
        input  chardata, isstring, ispattern,
        output busy, valid, match, match_index
    );
endinterface

// File: rtl/sme_char_cmp.sv
// Combinational character compare plus word-boundary flags.
//   s_char, p_char : string / pattern character ('.' in the pattern matches anything)
//   l_idx, l_prev  : candidate match start and the string character before it
//   r_idx, r_next  : candidate match end and the string character after it
//   slen           : current string length
//   eq             : characters match
//   l_edge         : l_idx is at string start or follows a space
//   r_edge         : r_idx is at string end or precedes a space
module sme_char_cmp
    import sme_pkg::*;
#(
    parameter int IW = 6
) (
    input  logic [7:0]    s_char,
    input  logic [7:0]    p_char,
    input  logic [IW-1:0] l_idx,
    input  logic [7:0]    l_prev,
    input  logic [IW-1:0] r_idx,
    input  logic [7:0]    r_next,
    input  logic [IW-1:0] slen,
    output logic          eq,
    output logic          l_edge,
    output logic          r_edge
);
    assign eq     = (p_char == CH_DOT) || (s_char == p_char);
    assign l_edge = (l_idx == '0) || (l_prev == CH_SPACE);
    // r_idx >= slen also catches the wrapped value produced by an empty span at index 0
    assign r_edge = (r_idx >= slen) || (r_idx + IW'(1) == slen) || (r_next == CH_SPACE);
endmodule

// File: rtl/sme_wild_matcher.sv
// Wildcard string-match engine.
// Loads a string and a pattern as byte streams, then searches for the pattern
// ('.', '^', '$' and one '*' gap supported) and pulses one result per job.
// A pattern-only job re-searches the previously stored string.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset; aborts any job in flight
//   bus   : character input and result outputs (slave side)
module sme_wild_matcher
    import sme_pkg::*;
#(
    parameter int STR_DEPTH = 32,
    parameter int PAT_DEPTH = 8,
    parameter int IDXW      = idx_w(STR_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    sme_wild_matcher_if.slave  bus
);
    // one extra bit so start + length never wraps
    localparam int IW = IDXW + 1;
    localparam int PW = (PAT_DEPTH > 1) ? $clog2(PAT_DEPTH) : 1;
    localparam logic [IW-1:0] STR_MAX = IW'(STR_DEPTH);
    localparam logic [IW-1:0] PAT_MAX = IW'(PAT_DEPTH);

    state_t        state;
    logic [7:0]    str_mem [STR_DEPTH];
    logic [7:0]    pat_mem [PAT_DEPTH];
    logic [IW-1:0] slen, plen, split;
    logic [IW-1:0] scan_i, scan_j, k;
    logic          anc_l, anc_r, has_star;
    logic          str_open, pat_open;   // string / pattern of the current job already begun
    logic          res_match;

    // ---------------- load-side decode ----------------
    logic [7:0]    ch;
    logic          ch_lit;
    logic [IW-1:0] p_plen, p_split;
    logic          p_l, p_r, p_star;

    // a fresh pattern starts from empty length and cleared flags
    always_comb begin
        ch      = bus.chardata;
        ch_lit  = !((ch == CH_CARET) || (ch == CH_DOLLAR) || (ch == CH_STAR));
        p_plen  = pat_open ? plen  : '0;
        p_split = pat_open ? split : '0;
        p_l     = pat_open && anc_l;
        p_r     = pat_open && anc_r;
        p_star  = pat_open && has_star;
    end

    // ---------------- search datapath ----------------
    logic [IW-1:0] pre_len, suf_len, base, lim_len, cmp_pos, pat_pos, end_pos, prev_pos, next_pos;
    logic [7:0]    s_char, p_char, l_prev, r_next;
    logic          eq, l_edge, r_edge, scan_fail;

    always_comb begin
        pre_len   = has_star ? split : plen;
        suf_len   = has_star ? (plen - split) : '0;
        base      = (state == S_SUF) ? scan_j  : scan_i;
        lim_len   = (state == S_SUF) ? suf_len : pre_len;
        cmp_pos   = base + k;
        pat_pos   = (state == S_SUF) ? (split + k) : k;
        end_pos   = base + lim_len - IW'(1);
        prev_pos  = scan_i - IW'(1);
        next_pos  = end_pos + IW'(1);
        // window no longer fits in the string (an empty string never matches)
        scan_fail = (slen == '0) || (base + lim_len > slen);
        // look-ups outside the stored string read as 0 and are treated as edges
        s_char    = (cmp_pos  < slen) ? str_mem[cmp_pos[IDXW-1:0]]  : 8'h00;
        l_prev    = (prev_pos < slen) ? str_mem[prev_pos[IDXW-1:0]] : 8'h00;
        r_next    = (next_pos < slen) ? str_mem[next_pos[IDXW-1:0]] : 8'h00;
        p_char    = pat_mem[pat_pos[PW-1:0]];
    end

    sme_char_cmp #(.IW(IW)) u_cmp (
        .s_char (s_char),
        .p_char (p_char),
        .l_idx  (scan_i),
        .l_prev (l_prev),
        .r_idx  (end_pos),
        .r_next (r_next),
        .slen   (slen),
        .eq     (eq),
        .l_edge (l_edge),
        .r_edge (r_edge)
    );

    // ---------------- storage (no reset needed on contents) ----------------
    always_ff @(posedge clk) begin
        if (state == S_LOAD && bus.isstring) begin
            if (!str_open)
                str_mem[0] <= ch;
            else if (slen < STR_MAX)
                str_mem[slen[IDXW-1:0]] <= ch;
        end
        if (state == S_LOAD && bus.ispattern && ch_lit && p_plen < PAT_MAX)
            pat_mem[p_plen[PW-1:0]] <= ch;
    end

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_LOAD;
            slen      <= '0;
            plen      <= '0;
            split     <= '0;
            anc_l     <= 1'b0;
            anc_r     <= 1'b0;
            has_star  <= 1'b0;
            str_open  <= 1'b0;
            pat_open  <= 1'b0;
            scan_i    <= '0;
            scan_j    <= '0;
            k         <= '0;
            res_match <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (bus.isstring) begin
                        str_open <= 1'b1;
                        if (!str_open)
                            slen <= IW'(1);
                        else if (slen < STR_MAX)
                            slen <= slen + IW'(1);
                    end else if (bus.ispattern) begin
                        pat_open <= 1'b1;
                        if (p_plen < PAT_MAX) begin
                            anc_l    <= p_l || (ch == CH_CARET);
                            anc_r    <= p_r || (ch == CH_DOLLAR);
                            has_star <= p_star || (ch == CH_STAR);
                            // split point latched once; a second '*' is not supported
                            split    <= (ch == CH_STAR && !p_star) ? p_plen : p_split;
                            plen     <= ch_lit ? p_plen + IW'(1) : p_plen;
                        end
                    end else if (pat_open) begin
                        state     <= S_PRE;
                        str_open  <= 1'b0;
                        pat_open  <= 1'b0;
                        scan_i    <= '0;
                        k         <= '0;
                        res_match <= 1'b0;
                    end
                end
                S_PRE: begin
                    if (scan_fail) begin
                        res_match <= 1'b0;
                        state     <= S_OUT;
                    end else if (k == pre_len) begin
                        // PRE matched at scan_i; '$' only applies here without a star
                        if ((!anc_l || l_edge) && (has_star || !anc_r || r_edge)) begin
                            if (has_star) begin
                                state  <= S_SUF;
                                scan_j <= scan_i + split;
                                k      <= '0;
                            end else begin
                                res_match <= 1'b1;
                                state     <= S_OUT;
                            end
                        end else begin
                            scan_i <= scan_i + IW'(1);
                            k      <= '0;
                        end
                    end else if (eq) begin
                        k <= k + IW'(1);
                    end else begin
                        scan_i <= scan_i + IW'(1);
                        k      <= '0;
                    end
                end
                S_SUF: begin
                    // later PRE positions only narrow the SUF range, so a SUF miss is final
                    if (suf_len == '0) begin
                        res_match <= 1'b1;
                        state     <= S_OUT;
                    end else if (scan_fail) begin
                        res_match <= 1'b0;
                        state     <= S_OUT;
                    end else if (k == suf_len) begin
                        if (!anc_r || r_edge) begin
                            res_match <= 1'b1;
                            state     <= S_OUT;
                        end else begin
                            scan_j <= scan_j + IW'(1);
                            k      <= '0;
                        end
                    end else if (eq) begin
                        k <= k + IW'(1);
                    end else begin
                        scan_j <= scan_j + IW'(1);
                        k      <= '0;
                    end
                end
                S_OUT: begin
                    state <= S_LOAD;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    // outputs decode from state so reset clears them immediately
    assign bus.valid       = (state == S_OUT);
    assign bus.match       = bus.valid && res_match;
    assign bus.match_index = bus.match ? scan_i[IDXW-1:0] : '0;
    assign bus.busy        = (state == S_PRE) || (state == S_SUF);

endmodule

// File: tb/tb_sme_wild_matcher.sv
// Self-checking bench for sme_wild_matcher: scoreboard of expected results,
// popped and compared whenever the engine pulses valid.
module tb_sme_wild_matcher;
    import sme_pkg::*;

    localparam int STR_DEPTH = 32;
    localparam int PAT_DEPTH = 8;
    localparam int IDXW      = 5;
    localparam int LAT_MAX   = STR_DEPTH * (PAT_DEPTH + 1) + 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    sme_wild_matcher_if #(.IDXW(IDXW)) bus ();

    sme_wild_matcher #(
        .STR_DEPTH (STR_DEPTH),
        .PAT_DEPTH (PAT_DEPTH),
        .IDXW      (IDXW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            match;
        logic [IDXW-1:0] idx;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // result monitor
    always @(negedge clk) begin
        if (reset && bus.valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_valid", 32'(bus.valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("match",         32'(bus.match),       32'(e.match));
                chk("match_index",   32'(bus.match_index), 32'(e.idx));
                chk("busy_at_valid", 32'(bus.busy),        32'd0);
            end
        end
    end

    task automatic send(input logic is_str, input string s);
        for (int n = 0; n < s.len(); n++) begin
            bus.chardata  = s[n];
            bus.isstring  = is_str;
            bus.ispattern = !is_str;
            @(negedge clk);
        end
        bus.isstring  = 1'b0;
        bus.ispattern = 1'b0;
    endtask

    // empty str => pattern-only job reusing the stored string
    task automatic run_job(input string tag, input string str, input string pat,
                           input logic m, input int idx);
        exp_t e;
        int   cyc;
        if (str.len() != 0) send(1'b1, str);
        send(1'b0, pat);
        e.match = m;
        e.idx   = IDXW'(idx);
        sb_q.push_back(e);
        @(negedge clk);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        cyc = 1;
        while (sb_q.size() != 0 && cyc < LAT_MAX + 10) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_in_bound"}, 32'(sb_q.size() == 0 && cyc <= LAT_MAX), 32'd1);
        sb_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        string a32;
        a32 = "";
        for (int n = 0; n < 32; n++) a32 = {a32, "a"};

        bus.chardata  = 8'h00;
        bus.isstring  = 1'b0;
        bus.ispattern = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.valid),       32'd0);
        chk("rst_match", 32'(bus.match),       32'd0);
        chk("rst_index", 32'(bus.match_index), 32'd0);
        chk("rst_busy",  32'(bus.busy),        32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_job("t1",  "THIS IS A BOOK", "IS",     1'b1, 2);
        run_job("t2",  "",               "^IS$",   1'b1, 5);
        run_job("t3a", "THIS IS A BOOK", "B.O*K$", 1'b1, 10);
        run_job("t3b", "",               "^A*X",   1'b0, 0);
        run_job("t4",  {a32, "bbb"},     "ab",     1'b0, 0);
        run_job("t5a", "HELLO WORLD",    "*$",     1'b1, 0);
        run_job("t5b", "",               "^.*",    1'b1, 0);
        run_job("t5c", "",               "L*D",    1'b1, 2);

        // abort a search in progress with reset
        send(1'b1, a32);
        send(1'b0, "ab");
        repeat (3) @(negedge clk);
        chk("t6_busy_pre", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.valid),       32'd0);
        chk("t6_match", 32'(bus.match),       32'd0);
        chk("t6_index", 32'(bus.match_index), 32'd0);
        chk("t6_busy",  32'(bus.busy),        32'd0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        run_job("t6b", "", "a", 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
